// File: rtl/alu_issue_stage_pkg.sv
// Shared opcode constants and FSM state type for the ALU issue stage.
package alu_issue_stage_pkg;

  // Operation codes presented to the ALU bit slices.
  localparam logic [2:0] OP_NONE = 3'b000;
  localparam logic [2:0] OP_AND  = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_SLT  = 3'b110;

  // Request opcodes arriving from upstream.
  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_NOR = 4'b1100;
  localparam logic [3:0] CTRL_SLT = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational translation of a request opcode into ALU slice controls.
module alu_ctrl_decode
  import alu_issue_stage_pkg::*;
(
  input  logic [3:0] aluctrl,
  output logic [2:0] op,
  output logic       ainv,
  output logic       binv,
  output logic       cin,
  output logic       illegal
);

  // Unknown opcodes leave every control at zero and raise the illegal flag.
  always_comb begin
    op      = OP_NONE;
    ainv    = 1'b0;
    binv    = 1'b0;
    cin     = 1'b0;
    illegal = 1'b0;
    case (aluctrl)
      CTRL_AND: op = OP_AND;
      CTRL_OR:  op = OP_OR;
      CTRL_ADD: op = OP_ADD;
      CTRL_SUB: begin
        op   = OP_SUB;
        binv = 1'b1;
        cin  = 1'b1;
      end
      CTRL_NOR: begin
        op   = OP_NOR;
        ainv = 1'b1;
        binv = 1'b1;
      end
      CTRL_SLT: begin
        op   = OP_SLT;
        binv = 1'b1;
        cin  = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage: latches a request, drives the external ALU array for one
// cycle, then holds the captured result until downstream takes it.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] src1_i,
  input  logic [31:0] src2_i,
  input  logic [3:0]  aluctrl_i,
  output logic [31:0] alu_src1_o,
  output logic [31:0] alu_src2_o,
  output logic [2:0]  alu_op_o,
  output logic        alu_ainv_o,
  output logic        alu_binv_o,
  output logic        alu_cin_o,
  input  logic [31:0] alu_result_i,
  input  logic        alu_ovf_i,
  input  logic        alu_cout_i,
  output logic        res_valid_o,
  input  logic        res_ready_i,
  output logic [31:0] result_o,
  output logic        zero_o,
  output logic        ovf_o,
  output logic        cout_o,
  output logic        err_o
);

  state_t state, next_state;
  logic       accept;
  logic       capture;
  logic [2:0] dec_op;
  logic       dec_ainv;
  logic       dec_binv;
  logic       dec_cin;
  logic       dec_illegal;
  logic       illegal_q;
  logic       carry_op;

  alu_ctrl_decode u_decode (
    .aluctrl (aluctrl_i),
    .op      (dec_op),
    .ainv    (dec_ainv),
    .binv    (dec_binv),
    .cin     (dec_cin),
    .illegal (dec_illegal)
  );

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    capture    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid_i) begin
          accept     = 1'b1;
          next_state = ST_EXEC;
        end
      end
      ST_EXEC: begin
        capture    = 1'b1;
        next_state = ST_DONE;
      end
      ST_DONE: begin
        if (res_ready_i) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  assign req_ready_o = (state == ST_IDLE);
  assign res_valid_o = (state == ST_DONE);

  // ALU-facing registers change only on accept, so they stay put through DONE.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      alu_src1_o <= '0;
      alu_src2_o <= '0;
      alu_op_o   <= OP_NONE;
      alu_ainv_o <= 1'b0;
      alu_binv_o <= 1'b0;
      alu_cin_o  <= 1'b0;
      illegal_q  <= 1'b0;
    end else if (accept) begin
      alu_src1_o <= src1_i;
      alu_src2_o <= src2_i;
      alu_op_o   <= dec_op;
      alu_ainv_o <= dec_ainv;
      alu_binv_o <= dec_binv;
      alu_cin_o  <= dec_cin;
      illegal_q  <= dec_illegal;
    end
  end

  assign carry_op = (alu_op_o == OP_ADD) || (alu_op_o == OP_SUB);

  // Flags from the MSB slice are only meaningful for arithmetic ops.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      result_o <= '0;
      zero_o   <= 1'b0;
      ovf_o    <= 1'b0;
      cout_o   <= 1'b0;
      err_o    <= 1'b0;
    end else if (capture) begin
      if (illegal_q) begin
        result_o <= '0;
        zero_o   <= 1'b1;
        ovf_o    <= 1'b0;
        cout_o   <= 1'b0;
        err_o    <= 1'b1;
      end else begin
        result_o <= alu_result_i;
        zero_o   <= (alu_result_i == 32'd0);
        ovf_o    <= carry_op & alu_ovf_i;
        cout_o   <= carry_op & alu_cout_i;
        err_o    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a small behavioural ALU array model.
module tb_alu_issue_stage;

  logic        clk_i = 1'b0;
  logic        rst_n;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] src1_i;
  logic [31:0] src2_i;
  logic [3:0]  aluctrl_i;
  logic [31:0] alu_src1_o;
  logic [31:0] alu_src2_o;
  logic [2:0]  alu_op_o;
  logic        alu_ainv_o;
  logic        alu_binv_o;
  logic        alu_cin_o;
  logic [31:0] alu_result_i;
  logic        alu_ovf_i;
  logic        alu_cout_i;
  logic        res_valid_o;
  logic        res_ready_i;
  logic [31:0] result_o;
  logic        zero_o;
  logic        ovf_o;
  logic        cout_o;
  logic        err_o;

  int n_cmp = 0;
  int n_err = 0;

  alu_issue_stage dut (
    .clk_i        (clk_i),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .src1_i       (src1_i),
    .src2_i       (src2_i),
    .aluctrl_i    (aluctrl_i),
    .alu_src1_o   (alu_src1_o),
    .alu_src2_o   (alu_src2_o),
    .alu_op_o     (alu_op_o),
    .alu_ainv_o   (alu_ainv_o),
    .alu_binv_o   (alu_binv_o),
    .alu_cin_o    (alu_cin_o),
    .alu_result_i (alu_result_i),
    .alu_ovf_i    (alu_ovf_i),
    .alu_cout_i   (alu_cout_i),
    .res_valid_o  (res_valid_o),
    .res_ready_i  (res_ready_i),
    .result_o     (result_o),
    .zero_o       (zero_o),
    .ovf_o        (ovf_o),
    .cout_o       (cout_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  // Stand-in for the external ALU array: invert, add/and/or, SLT from sign^ovf.
  logic [31:0] m_a, m_b;
  logic [32:0] m_sum;
  logic        m_ovf;
  always_comb begin
    m_a   = alu_ainv_o ? ~alu_src1_o : alu_src1_o;
    m_b   = alu_binv_o ? ~alu_src2_o : alu_src2_o;
    m_sum = {1'b0, m_a} + {1'b0, m_b} + {32'd0, alu_cin_o};
    m_ovf = (m_a[31] == m_b[31]) && (m_sum[31] != m_a[31]);
    case (alu_op_o)
      3'b001, 3'b101: alu_result_i = m_a & m_b;
      3'b010:         alu_result_i = m_a | m_b;
      3'b011, 3'b100: alu_result_i = m_sum[31:0];
      3'b110:         alu_result_i = {31'd0, m_sum[31] ^ m_ovf};
      default:        alu_result_i = 32'hDEADBEEF;
    endcase
    alu_ovf_i  = m_ovf;
    alu_cout_i = m_sum[32];
  end

  task automatic send_req(input logic [3:0] ctrl, input logic [31:0] a,
                          input logic [31:0] b, output int lat);
    int w;
    @(negedge clk_i);
    res_ready_i = 1'b0;
    req_valid_i = 1'b1;
    aluctrl_i   = ctrl;
    src1_i      = a;
    src2_i      = b;
    w = 0;
    while (!req_ready_o && w < 10) begin
      @(negedge clk_i);
      w++;
    end
    if (!req_ready_o) begin
      n_cmp++;
      n_err++;
      $display("[TB] FAIL req_ready_timeout: got 0, expected 1");
    end
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    src1_i      = 32'hA5A5A5A5;
    src2_i      = 32'h5A5A5A5A;
    aluctrl_i   = 4'b1111;
    lat = 1;
    while (!res_valid_o && lat < 10) begin
      @(negedge clk_i);
      lat++;
    end
  endtask

  task automatic release_result();
    res_ready_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    res_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    req_valid_i = 1'b0;
    res_ready_i = 1'b0;
    src1_i      = 32'd0;
    src2_i      = 32'd0;
    aluctrl_i   = 4'd0;
    @(negedge clk_i);
    @(negedge clk_i);
    n_cmp++; if (req_ready_o !== 1'b1) begin n_err++; $display("[TB] FAIL rst_req_ready: got %b, expected 1", req_ready_o); end
    n_cmp++; if (res_valid_o !== 1'b0) begin n_err++; $display("[TB] FAIL rst_res_valid: got %b, expected 0", res_valid_o); end
    n_cmp++; if ({alu_src1_o, alu_src2_o} !== 64'd0) begin n_err++; $display("[TB] FAIL rst_alu_src: got %h, expected 0", {alu_src1_o, alu_src2_o}); end
    n_cmp++; if ({alu_op_o, alu_ainv_o, alu_binv_o, alu_cin_o} !== 6'd0) begin n_err++; $display("[TB] FAIL rst_alu_ctrl: got %b, expected 000000", {alu_op_o, alu_ainv_o, alu_binv_o, alu_cin_o}); end
    n_cmp++; if ({result_o, zero_o, ovf_o, cout_o, err_o} !== 36'd0) begin n_err++; $display("[TB] FAIL rst_result: got %h, expected 0", {result_o, zero_o, ovf_o, cout_o, err_o}); end
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    int lat;
    send_req(4'b0010, 32'd5, 32'd3, lat);
    n_cmp++; if (lat !== 2) begin n_err++; $display("[TB] FAIL add_latency: got %0d, expected 2", lat); end
    n_cmp++; if (alu_op_o !== 3'b011) begin n_err++; $display("[TB] FAIL add_op: got %b, expected 011", alu_op_o); end
    n_cmp++; if (result_o !== 32'd8) begin n_err++; $display("[TB] FAIL add_result: got %h, expected 8", result_o); end
    n_cmp++; if ({zero_o, ovf_o, cout_o, err_o} !== 4'b0000) begin n_err++; $display("[TB] FAIL add_flags: got %b, expected 0000", {zero_o, ovf_o, cout_o, err_o}); end
    n_cmp++; if (req_ready_o !== 1'b0) begin n_err++; $display("[TB] FAIL add_ready_in_done: got %b, expected 0", req_ready_o); end
    release_result();
    n_cmp++; if ({req_ready_o, res_valid_o} !== 2'b10) begin n_err++; $display("[TB] FAIL add_back_to_idle: got %b, expected 10", {req_ready_o, res_valid_o}); end
  endtask

  task automatic test_sub();
    int lat;
    send_req(4'b0110, 32'd3, 32'd5, lat);
    n_cmp++; if ({alu_op_o, alu_ainv_o, alu_binv_o, alu_cin_o} !== 6'b100011) begin n_err++; $display("[TB] FAIL sub_ctrl: got %b, expected 100011", {alu_op_o, alu_ainv_o, alu_binv_o, alu_cin_o}); end
    n_cmp++; if (result_o !== 32'hFFFFFFFE) begin n_err++; $display("[TB] FAIL sub_result: got %h, expected fffffffe", result_o); end
    n_cmp++; if ({zero_o, ovf_o, cout_o} !== 3'b000) begin n_err++; $display("[TB] FAIL sub_flags: got %b, expected 000", {zero_o, ovf_o, cout_o}); end
    release_result();
  endtask

  task automatic test_overflow();
    int lat;
    send_req(4'b0010, 32'h7FFFFFFF, 32'd1, lat);
    n_cmp++; if (result_o !== 32'h80000000) begin n_err++; $display("[TB] FAIL ovf_result: got %h, expected 80000000", result_o); end
    n_cmp++; if ({ovf_o, cout_o, zero_o} !== 3'b100) begin n_err++; $display("[TB] FAIL ovf_flags: got %b, expected 100", {ovf_o, cout_o, zero_o}); end
    release_result();
  endtask

  task automatic test_illegal();
    int lat;
    send_req(4'b1111, 32'd5, 32'd5, lat);
    n_cmp++; if (lat !== 2) begin n_err++; $display("[TB] FAIL ill_latency: got %0d, expected 2", lat); end
    n_cmp++; if ({alu_op_o, alu_ainv_o, alu_binv_o, alu_cin_o} !== 6'd0) begin n_err++; $display("[TB] FAIL ill_ctrl: got %b, expected 000000", {alu_op_o, alu_ainv_o, alu_binv_o, alu_cin_o}); end
    n_cmp++; if (result_o !== 32'd0) begin n_err++; $display("[TB] FAIL ill_result: got %h, expected 0", result_o); end
    n_cmp++; if ({zero_o, ovf_o, cout_o, err_o} !== 4'b1001) begin n_err++; $display("[TB] FAIL ill_flags: got %b, expected 1001", {zero_o, ovf_o, cout_o, err_o}); end
    release_result();
  endtask

  task automatic test_logic();
    logic [3:0]  ctrl  [6] = '{4'b0000, 4'b0001, 4'b1100, 4'b0111, 4'b0111, 4'b0110};
    logic [31:0] a     [6] = '{32'hFFFFFFFF, 32'hF0F00000, 32'h0000FFFF, 32'd3, 32'd5, 32'd7};
    logic [31:0] b     [6] = '{32'h00000001, 32'h0000000F, 32'h00FF0000, 32'd5, 32'd3, 32'd7};
    logic [5:0]  ectl  [6] = '{6'b001000, 6'b010000, 6'b101110, 6'b110011, 6'b110011, 6'b100011};
    logic [31:0] eres  [6] = '{32'd1, 32'hF0F0000F, 32'hFF000000, 32'd1, 32'd0, 32'd0};
    logic [3:0]  eflg  [6] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b1010};
    int lat;
    for (int i = 0; i < 6; i++) begin
      send_req(ctrl[i], a[i], b[i], lat);
      n_cmp++; if ({alu_op_o, alu_ainv_o, alu_binv_o, alu_cin_o} !== ectl[i]) begin n_err++; $display("[TB] FAIL logic%0d_ctrl: got %b, expected %b", i, {alu_op_o, alu_ainv_o, alu_binv_o, alu_cin_o}, ectl[i]); end
      n_cmp++; if (result_o !== eres[i]) begin n_err++; $display("[TB] FAIL logic%0d_result: got %h, expected %h", i, result_o, eres[i]); end
      n_cmp++; if ({zero_o, ovf_o, cout_o, err_o} !== eflg[i]) begin n_err++; $display("[TB] FAIL logic%0d_flags: got %b, expected %b", i, {zero_o, ovf_o, cout_o, err_o}, eflg[i]); end
      release_result();
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    send_req(4'b0010, 32'h12345678, 32'h11111111, lat);
    // A new request waits upstream while the old result is held.
    req_valid_i = 1'b1;
    aluctrl_i   = 4'b0010;
    src1_i      = 32'd10;
    src2_i      = 32'd20;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      n_cmp++; if ({res_valid_o, req_ready_o, result_o} !== {2'b10, 32'h23456789}) begin n_err++; $display("[TB] FAIL bp_hold%0d: got %h, expected 223456789", i, {res_valid_o, req_ready_o, result_o}); end
    end
    n_cmp++; if (alu_src1_o !== 32'h12345678) begin n_err++; $display("[TB] FAIL bp_src_hold: got %h, expected 12345678", alu_src1_o); end
    release_result();
    n_cmp++; if ({req_ready_o, res_valid_o} !== 2'b10) begin n_err++; $display("[TB] FAIL bp_release: got %b, expected 10", {req_ready_o, res_valid_o}); end
    @(negedge clk_i);
    req_valid_i = 1'b0;
    n_cmp++; if (req_ready_o !== 1'b0) begin n_err++; $display("[TB] FAIL b2b_accept: got %b, expected 0", req_ready_o); end
    @(negedge clk_i);
    n_cmp++; if ({res_valid_o, result_o} !== {1'b1, 32'd30}) begin n_err++; $display("[TB] FAIL b2b_result: got %h, expected 10000001e", {res_valid_o, result_o}); end
    release_result();
  endtask

  task automatic test_reset_mid();
    @(negedge clk_i);
    req_valid_i = 1'b1;
    aluctrl_i   = 4'b0010;
    src1_i      = 32'd1;
    src2_i      = 32'd2;
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({req_ready_o, res_valid_o} !== 2'b10) begin n_err++; $display("[TB] FAIL rmid_immediate: got %b, expected 10", {req_ready_o, res_valid_o}); end
    @(negedge clk_i);
    n_cmp++; if ({res_valid_o, result_o} !== 33'd0) begin n_err++; $display("[TB] FAIL rmid_no_result: got %h, expected 0", {res_valid_o, result_o}); end
    @(negedge clk_i);
    rst_n       = 1'b1;
    req_valid_i = 1'b1;
    src1_i      = 32'd4;
    src2_i      = 32'd4;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    n_cmp++; if ({req_ready_o, res_valid_o} !== 2'b00) begin n_err++; $display("[TB] FAIL rmid_first_edge: got %b, expected 00", {req_ready_o, res_valid_o}); end
    @(negedge clk_i);
    n_cmp++; if ({res_valid_o, result_o} !== {1'b1, 32'd8}) begin n_err++; $display("[TB] FAIL rmid_after: got %h, expected 100000008", {res_valid_o, result_o}); end
    release_result();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_overflow();
    test_illegal();
    test_logic();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
